// File: rtl/room_transition_ctrl_if.sv
// Player / tile-map / VGA-side signal bundle for the room transition controller.
interface room_transition_ctrl_if;
    logic       frame_tick;
    logic       exit_req;
    logic [1:0] exit_dir;
    logic [2:0] map_rd_x;
    logic [2:0] map_rd_y;
    logic [5:0] map_rd_code;
    logic [2:0] mapa_x_pos;
    logic [2:0] mapa_y_pos;
    logic [5:0] tile_code;
    logic       exit_ack;
    logic       exit_nak;
    logic       blank;
    logic       player_hold;
    logic       spawn_valid;
    logic [1:0] spawn_side;
    logic       win;

    // Controller side.
    modport master (
        input  frame_tick, exit_req, exit_dir, map_rd_code,
        output map_rd_x, map_rd_y, mapa_x_pos, mapa_y_pos, tile_code,
               exit_ack, exit_nak, blank, player_hold, spawn_valid, spawn_side, win
    );

    // Player, tile-map ROM and VGA mux side.
    modport slave (
        output frame_tick, exit_req, exit_dir, map_rd_code,
        input  map_rd_x, map_rd_y, mapa_x_pos, mapa_y_pos, tile_code,
               exit_ack, exit_nak, blank, player_hold, spawn_valid, spawn_side, win
    );
endinterface

// File: rtl/room_transition_ctrl.sv
// Room (tile) change sequencer: validates an edge exit against the tile map,
// blanks the screen for a number of frames, then publishes the new room.
module room_transition_ctrl #(
    parameter int unsigned MAP_W       = 8,
    parameter int unsigned MAP_H       = 8,
    parameter int unsigned START_X     = 0,
    parameter int unsigned START_Y     = 0,
    parameter int unsigned GOAL_X      = 7,
    parameter int unsigned GOAL_Y      = 7,
    parameter int unsigned FADE_FRAMES = 4
) (
    input  logic                   CLOCK_25,
    input  logic                   reset,
    room_transition_ctrl_if.master bus
);

    localparam int unsigned COORD_W = 3;
    localparam int unsigned CODE_W  = 6;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned FADE_W  = (FADE_FRAMES < 1) ? 1 : $clog2(FADE_FRAMES + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_INIT_W,
        ST_IDLE,
        ST_CHECK1,
        ST_CHECK2,
        ST_FADE,
        ST_SPAWN,
        ST_DONE
    } state_t;

    state_t              state;
    logic [COORD_W-1:0]  pos_x, pos_y;
    logic [COORD_W-1:0]  rd_x, rd_y;
    logic [COORD_W-1:0]  tgt_x, tgt_y;
    logic [CODE_W-1:0]   tile_q, tgt_code;
    logic [MASK_W-1:0]   cur_mask, tgt_mask;
    logic [1:0]          dir_q;
    logic [FADE_W-1:0]   fade_cnt;
    logic                ack_q, nak_q, blank_q, hold_q, spawn_q, win_q;
    logic [1:0]          side_q;

    logic [COORD_W-1:0]  step_x_c, step_y_c;
    logic                step_in_map_c;
    logic [MASK_W-1:0]   rd_mask_c;
    logic [1:0]          opp_dir_c;
    logic                at_goal_c;

    // Openings per tile code, bit order {L,D,R,U} so a direction code indexes it directly.
    function automatic logic [MASK_W-1:0] open_mask(input logic [CODE_W-1:0] code);
        case (code)
            6'd0:    open_mask = 4'b0101;
            6'd1:    open_mask = 4'b1010;
            6'd2:    open_mask = 4'b1001;
            6'd3:    open_mask = 4'b0011;
            6'd4:    open_mask = 4'b0110;
            6'd5:    open_mask = 4'b1100;
            6'd6:    open_mask = 4'b1111;
            6'd7:    open_mask = 4'b0100;
            6'd8:    open_mask = 4'b1000;
            6'd9:    open_mask = 4'b0001;
            6'd10:   open_mask = 4'b0010;
            6'd11:   open_mask = 4'b1110;
            6'd12:   open_mask = 4'b1101;
            6'd13:   open_mask = 4'b1011;
            6'd14:   open_mask = 4'b0111;
            default: open_mask = 4'b0000;
        endcase
    endfunction

    // Neighbour of the current tile in the requested direction; range is judged before the coordinate wraps.
    always_comb begin
        step_x_c      = pos_x;
        step_y_c      = pos_y;
        step_in_map_c = 1'b0;
        case (bus.exit_dir)
            2'd0: begin
                step_y_c      = pos_y - COORD_W'(1);
                step_in_map_c = (pos_y != '0);
            end
            2'd1: begin
                step_x_c      = pos_x + COORD_W'(1);
                step_in_map_c = (32'(pos_x) + 32'd1 < MAP_W);
            end
            2'd2: begin
                step_y_c      = pos_y + COORD_W'(1);
                step_in_map_c = (32'(pos_y) + 32'd1 < MAP_H);
            end
            default: begin
                step_x_c      = pos_x - COORD_W'(1);
                step_in_map_c = (pos_x != '0);
            end
        endcase
    end

    // Helpers for the map read result and the pending move.
    always_comb begin
        rd_mask_c = open_mask(bus.map_rd_code);
        opp_dir_c = dir_q ^ 2'd2;
        at_goal_c = (tgt_x == COORD_W'(GOAL_X)) && (tgt_y == COORD_W'(GOAL_Y));
    end

    // Transition sequencer; every output is a register updated here.
    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            pos_x    <= COORD_W'(START_X);
            pos_y    <= COORD_W'(START_Y);
            rd_x     <= COORD_W'(START_X);
            rd_y     <= COORD_W'(START_Y);
            tgt_x    <= COORD_W'(START_X);
            tgt_y    <= COORD_W'(START_Y);
            tile_q   <= '0;
            tgt_code <= '0;
            cur_mask <= '0;
            tgt_mask <= '0;
            dir_q    <= '0;
            fade_cnt <= '0;
            ack_q    <= 1'b0;
            nak_q    <= 1'b0;
            blank_q  <= 1'b1;
            hold_q   <= 1'b1;
            spawn_q  <= 1'b0;
            side_q   <= '0;
            win_q    <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            nak_q   <= 1'b0;
            spawn_q <= 1'b0;
            case (state)
                ST_INIT: begin
                    state <= ST_INIT_W;
                end
                ST_INIT_W: begin
                    tile_q   <= bus.map_rd_code;
                    cur_mask <= rd_mask_c;
                    blank_q  <= 1'b0;
                    hold_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.exit_req) begin
                        if (cur_mask[bus.exit_dir] && step_in_map_c) begin
                            tgt_x  <= step_x_c;
                            tgt_y  <= step_y_c;
                            rd_x   <= step_x_c;
                            rd_y   <= step_y_c;
                            dir_q  <= bus.exit_dir;
                            hold_q <= 1'b1;
                            state  <= ST_CHECK1;
                        end else begin
                            nak_q <= 1'b1;
                        end
                    end
                end
                ST_CHECK1: begin
                    state <= ST_CHECK2;
                end
                ST_CHECK2: begin
                    if (rd_mask_c[opp_dir_c]) begin
                        ack_q    <= 1'b1;
                        blank_q  <= 1'b1;
                        fade_cnt <= '0;
                        tgt_code <= bus.map_rd_code;
                        tgt_mask <= rd_mask_c;
                        state    <= ST_FADE;
                    end else begin
                        nak_q  <= 1'b1;
                        rd_x   <= pos_x;
                        rd_y   <= pos_y;
                        hold_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_FADE: begin
                    if (fade_cnt == FADE_W'(FADE_FRAMES)) begin
                        pos_x    <= tgt_x;
                        pos_y    <= tgt_y;
                        tile_q   <= tgt_code;
                        cur_mask <= tgt_mask;
                        spawn_q  <= 1'b1;
                        side_q   <= opp_dir_c;
                        blank_q  <= 1'b0;
                        hold_q   <= at_goal_c;
                        win_q    <= at_goal_c;
                        state    <= ST_SPAWN;
                    end else if (bus.frame_tick) begin
                        fade_cnt <= fade_cnt + FADE_W'(1);
                    end
                end
                ST_SPAWN: begin
                    state <= win_q ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    hold_q <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Registered state onto the bus.
    assign bus.map_rd_x    = rd_x;
    assign bus.map_rd_y    = rd_y;
    assign bus.mapa_x_pos  = pos_x;
    assign bus.mapa_y_pos  = pos_y;
    assign bus.tile_code   = tile_q;
    assign bus.exit_ack    = ack_q;
    assign bus.exit_nak    = nak_q;
    assign bus.blank       = blank_q;
    assign bus.player_hold = hold_q;
    assign bus.spawn_valid = spawn_q;
    assign bus.spawn_side  = side_q;
    assign bus.win         = win_q;

endmodule

// File: tb/tb_room_transition_ctrl.sv
// Bench for room_transition_ctrl: tile-map ROM, frame ticks, directed exit requests,
// a per-cycle reference model and hand-computed spot checks.
module tb_room_transition_ctrl;

    localparam int FADE_FRAMES = 4;
    localparam int START_X     = 0;
    localparam int START_Y     = 0;

    localparam int PH_BOOT  = 0;
    localparam int PH_IDLE  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_FADE  = 3;
    localparam int PH_SPAWN = 4;
    localparam int PH_DONE  = 5;

    logic CLOCK_25;
    logic reset;
    room_transition_ctrl_if bus();

    room_transition_ctrl #(
        .MAP_W(8), .MAP_H(8), .START_X(START_X), .START_Y(START_Y),
        .GOAL_X(7), .GOAL_Y(7), .FADE_FRAMES(FADE_FRAMES)
    ) dut (
        .CLOCK_25(CLOCK_25),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rom [8][8];
    string open_tbl [15] = '{"UD", "LR", "UL", "UR", "DR", "DL", "URDL", "D", "L", "U", "R",
                             "RDL", "UDL", "URL", "URD"};

    // Expected outputs and model bookkeeping.
    int e_px, e_py, e_rx, e_ry, e_code, e_side;
    bit e_ack, e_nak, e_blank, e_hold, e_spawn, e_win;
    int m_phase, m_boot, m_age, m_ticks, m_tx, m_ty, m_dir, m_tcode;

    initial begin
        CLOCK_25 = 1'b0;
        forever #10 CLOCK_25 = ~CLOCK_25;
    end

    // Tile-map ROM with one cycle of read latency.
    always @(posedge CLOCK_25) bus.map_rd_code <= 6'(rom[bus.map_rd_y][bus.map_rd_x]);

    // Frame tick every sixth cycle.
    initial begin
        bus.frame_tick = 1'b0;
        forever begin
            repeat (5) @(negedge CLOCK_25);
            bus.frame_tick = 1'b1;
            @(negedge CLOCK_25);
            bus.frame_tick = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit opens(input int code, input int d);
        string dirs;
        string s;
        bit r;
        dirs = "URDL";
        r = 1'b0;
        if (code >= 0 && code < 15) begin
            s = open_tbl[code];
            for (int i = 0; i < s.len(); i++)
                if (s[i] == dirs[d]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic int step_x(input int x, input int d);
        return x + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
    endfunction

    function automatic int step_y(input int y, input int d);
        return y + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
    endfunction

    function automatic bit in_map(input int x, input int y);
        return (x >= 0) && (x < 8) && (y >= 0) && (y < 8);
    endfunction

    // Reference model: what the outputs must be after each clock edge.
    always @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            m_phase <= PH_BOOT; m_boot <= 0; m_age <= 0; m_ticks <= 0;
            m_tx <= 0; m_ty <= 0; m_dir <= 0; m_tcode <= 0;
            e_px <= START_X; e_py <= START_Y; e_rx <= START_X; e_ry <= START_Y;
            e_code <= 0; e_side <= 0;
            e_ack <= 0; e_nak <= 0; e_blank <= 1; e_hold <= 1; e_spawn <= 0; e_win <= 0;
        end else begin
            e_ack <= 0; e_nak <= 0; e_spawn <= 0;
            case (m_phase)
                PH_BOOT: begin
                    m_boot <= m_boot + 1;
                    if (m_boot == 1) begin
                        e_code <= rom[START_Y][START_X];
                        e_blank <= 0; e_hold <= 0;
                        m_phase <= PH_IDLE;
                    end
                end
                PH_IDLE: begin
                    if (bus.exit_req) begin
                        if (opens(e_code, int'(bus.exit_dir)) &&
                            in_map(step_x(e_px, int'(bus.exit_dir)), step_y(e_py, int'(bus.exit_dir)))) begin
                            m_tx <= step_x(e_px, int'(bus.exit_dir));
                            m_ty <= step_y(e_py, int'(bus.exit_dir));
                            e_rx <= step_x(e_px, int'(bus.exit_dir));
                            e_ry <= step_y(e_py, int'(bus.exit_dir));
                            m_dir <= int'(bus.exit_dir);
                            e_hold <= 1; m_age <= 0;
                            m_phase <= PH_CHECK;
                        end else begin
                            e_nak <= 1;
                        end
                    end
                end
                PH_CHECK: begin
                    m_age <= m_age + 1;
                    if (m_age == 1) begin
                        if (opens(rom[m_ty][m_tx], (m_dir + 2) % 4)) begin
                            e_ack <= 1; e_blank <= 1;
                            m_tcode <= rom[m_ty][m_tx]; m_ticks <= 0;
                            m_phase <= PH_FADE;
                        end else begin
                            e_nak <= 1; e_rx <= e_px; e_ry <= e_py; e_hold <= 0;
                            m_phase <= PH_IDLE;
                        end
                    end
                end
                PH_FADE: begin
                    if (m_ticks == FADE_FRAMES) begin
                        e_px <= m_tx; e_py <= m_ty; e_code <= m_tcode;
                        e_spawn <= 1; e_side <= (m_dir + 2) % 4; e_blank <= 0;
                        e_hold <= (m_tx == 7 && m_ty == 7);
                        e_win <= (m_tx == 7 && m_ty == 7);
                        m_phase <= PH_SPAWN;
                    end else if (bus.frame_tick) begin
                        m_ticks <= m_ticks + 1;
                    end
                end
                PH_SPAWN: m_phase <= e_win ? PH_DONE : PH_IDLE;
                default: ;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLOCK_25) begin
        chk("map_rd_x", int'(bus.map_rd_x), e_rx);
        chk("map_rd_y", int'(bus.map_rd_y), e_ry);
        chk("mapa_x_pos", int'(bus.mapa_x_pos), e_px);
        chk("mapa_y_pos", int'(bus.mapa_y_pos), e_py);
        chk("tile_code", int'(bus.tile_code), e_code);
        chk("exit_ack", int'(bus.exit_ack), int'(e_ack));
        chk("exit_nak", int'(bus.exit_nak), int'(e_nak));
        chk("blank", int'(bus.blank), int'(e_blank));
        chk("player_hold", int'(bus.player_hold), int'(e_hold));
        chk("spawn_valid", int'(bus.spawn_valid), int'(e_spawn));
        chk("spawn_side", int'(bus.spawn_side), e_side);
        chk("win", int'(bus.win), int'(e_win));
    end

    task automatic pulse_req(input int d);
        bus.exit_dir = 2'(d);
        bus.exit_req = 1'b1;
        @(negedge CLOCK_25);
        bus.exit_req = 1'b0;
    endtask

    task automatic wait_spawn(input string name);
        int n;
        n = 0;
        while (!bus.spawn_valid && n < 200) begin
            @(negedge CLOCK_25);
            n++;
        end
        chk(name, int'(bus.spawn_valid), 1);
    endtask

    task automatic move(input int d);
        pulse_req(d);
        wait_spawn("move_spawn_timeout");
        @(negedge CLOCK_25);
    endtask

    task automatic fill_rom(input int code);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                rom[y][x] = code;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        bus.exit_req = 1'b0;
        bus.exit_dir = 2'd0;
        fill_rom(15);
        rom[0][0] = 10;
        rom[0][1] = 1;
        rom[0][2] = 1;
        repeat (3) @(negedge CLOCK_25);
        reset = 1'b1;

        // Start-up: two cycles to the first valid room.
        repeat (2) @(negedge CLOCK_25);
        chk("boot_tile", int'(bus.tile_code), 10);
        chk("boot_pos_x", int'(bus.mapa_x_pos), 0);
        chk("boot_blank", int'(bus.blank), 0);
        chk("boot_hold", int'(bus.player_hold), 0);

        // Up from (0,0): refused one cycle later, no read of the target.
        pulse_req(0);
        chk("up_nak", int'(bus.exit_nak), 1);
        chk("up_rd_y", int'(bus.map_rd_y), 0);
        chk("up_pos_y", int'(bus.mapa_y_pos), 0);

        // Right from (0,0): read (1,0), ack three cycles after the request, spawn on the left edge.
        pulse_req(1);
        chk("right_rd_x", int'(bus.map_rd_x), 1);
        chk("right_hold", int'(bus.player_hold), 1);
        chk("right_ack_early", int'(bus.exit_ack), 0);
        repeat (2) @(negedge CLOCK_25);
        chk("right_ack", int'(bus.exit_ack), 1);
        chk("right_blank", int'(bus.blank), 1);
        chk("right_pos_held", int'(bus.mapa_x_pos), 0);
        wait_spawn("right_spawn_timeout");
        chk("right_pos_x", int'(bus.mapa_x_pos), 1);
        chk("right_side", int'(bus.spawn_side), 3);
        chk("right_tile", int'(bus.tile_code), 1);
        @(negedge CLOCK_25);

        // Open map: walk to (7,3).
        fill_rom(6);
        repeat (6) move(1);
        repeat (3) move(2);
        chk("walk_pos_x", int'(bus.mapa_x_pos), 7);
        chk("walk_pos_y", int'(bus.mapa_y_pos), 3);

        // Right edge of the map: refused, no wrap to column 0.
        pulse_req(1);
        chk("edge_nak", int'(bus.exit_nak), 1);
        chk("edge_pos_x", int'(bus.mapa_x_pos), 7);
        chk("edge_rd_x", int'(bus.map_rd_x), 7);

        // Target tile closed on the entry side: refused after the map read.
        rom[3][6] = 0;
        pulse_req(3);
        chk("closed_rd_x", int'(bus.map_rd_x), 6);
        repeat (2) @(negedge CLOCK_25);
        chk("closed_nak", int'(bus.exit_nak), 1);
        chk("closed_rd_back", int'(bus.map_rd_x), 7);
        chk("closed_pos_x", int'(bus.mapa_x_pos), 7);
        rom[3][6] = 6;

        // Down to the goal.
        repeat (3) move(2);
        pulse_req(2);
        wait_spawn("goal_spawn_timeout");
        chk("goal_win", int'(bus.win), 1);
        chk("goal_pos_y", int'(bus.mapa_y_pos), 7);
        chk("goal_hold", int'(bus.player_hold), 1);
        @(negedge CLOCK_25);
        pulse_req(0);
        repeat (4) @(negedge CLOCK_25);
        chk("done_pos_y", int'(bus.mapa_y_pos), 7);
        chk("done_win", int'(bus.win), 1);
        chk("done_blank", int'(bus.blank), 0);

        // Reset in the middle of a fade.
        reset = 1'b0;
        @(negedge CLOCK_25);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_25);
        chk("reboot_tile", int'(bus.tile_code), 6);
        chk("reboot_win", int'(bus.win), 0);
        pulse_req(1);
        n = 0;
        while (!bus.blank && n < 20) begin
            @(negedge CLOCK_25);
            n++;
        end
        repeat (2) @(negedge CLOCK_25);
        chk("fade_blank", int'(bus.blank), 1);
        chk("fade_rd_x", int'(bus.map_rd_x), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_pos_x", int'(bus.mapa_x_pos), 0);
        chk("rst_rd_x", int'(bus.map_rd_x), 0);
        chk("rst_hold", int'(bus.player_hold), 1);
        @(negedge CLOCK_25);
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_25);
        chk("rst_boot_blank", int'(bus.blank), 0);
        chk("rst_boot_pos_x", int'(bus.mapa_x_pos), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
